// File: rtl/alu_collector_pkg.sv
// Shared types, operand masks, command encodings and operand-requirement
// helpers for the ALU operand collector.
package alu_collector_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        ISSUE = 2'd2
    } state_e;

    // Operand masks, bit 0 = A, bit 1 = B (same layout as inp_valid).
    localparam logic [1:0] OP_A  = 2'b01;
    localparam logic [1:0] OP_B  = 2'b10;
    localparam logic [1:0] OP_AB = 2'b11;

    // Commands are widened to this width before decoding.
    localparam int CMD_ARG_W = 8;
    typedef logic [CMD_ARG_W-1:0] cmd_arg_t;

    // Arithmetic commands (mode = 1).
    localparam cmd_arg_t ARITH_ADD     = 8'd0,  ARITH_SUB     = 8'd1;
    localparam cmd_arg_t ARITH_ADD_CIN = 8'd2,  ARITH_SUB_CIN = 8'd3;
    localparam cmd_arg_t ARITH_INC_A   = 8'd4,  ARITH_DEC_A   = 8'd5;
    localparam cmd_arg_t ARITH_INC_B   = 8'd6,  ARITH_DEC_B   = 8'd7;
    localparam cmd_arg_t ARITH_CMP     = 8'd8,  ARITH_MUL_INC = 8'd9;
    localparam cmd_arg_t ARITH_MUL_SHL = 8'd10;
    localparam cmd_arg_t ARITH_CMD_MAX = ARITH_MUL_SHL;

    // Logical commands (mode = 0).
    localparam cmd_arg_t LOGIC_AND    = 8'd0,  LOGIC_NAND   = 8'd1;
    localparam cmd_arg_t LOGIC_OR     = 8'd2,  LOGIC_NOR    = 8'd3;
    localparam cmd_arg_t LOGIC_XOR    = 8'd4,  LOGIC_XNOR   = 8'd5;
    localparam cmd_arg_t LOGIC_NOT_A  = 8'd6,  LOGIC_NOT_B  = 8'd7;
    localparam cmd_arg_t LOGIC_SHR1_A = 8'd8,  LOGIC_SHR1_B = 8'd9;
    localparam cmd_arg_t LOGIC_SHL1_A = 8'd10, LOGIC_SHL1_B = 8'd11;
    localparam cmd_arg_t LOGIC_ROL    = 8'd12, LOGIC_ROR    = 8'd13;
    localparam cmd_arg_t LOGIC_CMD_MAX = LOGIC_ROR;

    // Which operands an operation actually consumes.
    function automatic logic [1:0] req_ops(input logic mode, input cmd_arg_t cmd);
        logic [1:0] need;
        need = OP_AB;
        if (mode) begin
            if (cmd == ARITH_INC_A || cmd == ARITH_DEC_A)      need = OP_A;
            else if (cmd == ARITH_INC_B || cmd == ARITH_DEC_B) need = OP_B;
        end else begin
            if (cmd == LOGIC_NOT_A || cmd == LOGIC_SHR1_A || cmd == LOGIC_SHL1_A)
                need = OP_A;
            else if (cmd == LOGIC_NOT_B || cmd == LOGIC_SHR1_B || cmd == LOGIC_SHL1_B)
                need = OP_B;
        end
        return need;
    endfunction

    // Commands the ALU does not implement in the given mode.
    function automatic logic cmd_illegal(input logic mode, input cmd_arg_t cmd);
        return mode ? (cmd > ARITH_CMD_MAX) : (cmd > LOGIC_CMD_MAX);
    endfunction

endpackage

// File: rtl/alu_operand_collector_if.sv
// Valid/ready source bus feeding the operand collector. The source drives
// the beat (master); the collector answers with in_ready (slave).
interface alu_operand_collector_if #(
    parameter int DATA_WIDTH = 8,
    parameter int CMD_WIDTH  = 4
);
    logic                  in_valid;
    logic                  in_ready;
    logic [1:0]            in_sel;
    logic [DATA_WIDTH-1:0] in_opa;
    logic [DATA_WIDTH-1:0] in_opb;
    logic [CMD_WIDTH-1:0]  in_cmd;
    logic                  in_mode;
    logic                  in_cin;

    modport master (
        output in_valid, in_sel, in_opa, in_opb, in_cmd, in_mode, in_cin,
        input  in_ready
    );

    modport slave (
        input  in_valid, in_sel, in_opa, in_opb, in_cmd, in_mode, in_cin,
        output in_ready
    );
endinterface

// File: rtl/alu_collector_timer.sv
// CE-gated wait counter for a missing operand. clr has priority over inc;
// expired is high while the count sits at TIMEOUT_CYC-1.
module alu_collector_timer #(
    parameter int TIMEOUT_CYC = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic ce,
    input  logic clr,
    input  logic inc,
    output logic expired
);
    localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYC - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign expired = (cnt_q == LAST);

    // Next count: frozen while CE is low, saturates at the expiry value.
    always_comb begin
        cnt_d = cnt_q;
        if (ce) begin
            if (clr)                  cnt_d = '0;
            else if (inc && !expired) cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end
endmodule

// File: rtl/alu_operand_collector.sv
// Issue stage in front of the ALU: collects OPA/OPB (possibly in separate
// beats) plus CMD/mode/Cin, then presents one registered operation with its
// inp_valid mask for a single CE-high cycle. A missing operand is bounded by
// TIMEOUT_CYC CE-high cycles, after which the partial op is issued.
// Optional build macro: ALU_CMDCHK_EN -- drop first beats carrying an
// unimplemented command and pulse cmd_err instead of issuing.
module alu_operand_collector
    import alu_collector_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int CMD_WIDTH   = 4,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic                  clk,
    input  logic                  RST_N,
    input  logic                  CE,
    alu_operand_collector_if.slave src,
    output logic [DATA_WIDTH-1:0] OPA,
    output logic [DATA_WIDTH-1:0] OPB,
    output logic [CMD_WIDTH-1:0]  CMD,
    output logic                  mode,
    output logic                  Cin,
    output logic [1:0]            inp_valid,
    output logic                  timeout,
    output logic                  cmd_err,
    output logic                  busy
);
    // Collection state and operand slots (slots are never cleared).
    state_e                state_q, state_d;
    logic [1:0]            have_q, have_d;
    logic [DATA_WIDTH-1:0] opa_q, opa_d, opb_q, opb_d;
    logic [CMD_WIDTH-1:0]  cmd_q, cmd_d;
    logic                  mode_q, mode_d, cin_q, cin_d;
    // Registered view presented to the ALU; only reloaded on entry to ISSUE.
    logic [DATA_WIDTH-1:0] iss_opa_q, iss_opa_d, iss_opb_q, iss_opb_d;
    logic [CMD_WIDTH-1:0]  iss_cmd_q, iss_cmd_d;
    logic                  iss_mode_q, iss_mode_d, iss_cin_q, iss_cin_d;
    logic [1:0]            inp_valid_q, inp_valid_d;
    logic                  timeout_q, timeout_d, cmd_err_q, cmd_err_d;

    logic       accept, cmd_bad, expired;
    logic [1:0] need;

    assign src.in_ready = CE && RST_N && (state_q == IDLE || state_q == WAIT);
    assign accept       = src.in_valid && src.in_ready;

`ifdef ALU_CMDCHK_EN
    assign cmd_bad = cmd_illegal(src.in_mode, CMD_ARG_W'(src.in_cmd));
`else
    assign cmd_bad = 1'b0;
`endif

    alu_collector_timer #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_timer (
        .clk     (clk),
        .rst_n   (RST_N),
        .ce      (CE),
        .clr     (state_q != WAIT),
        .inc     (state_q == WAIT),
        .expired (expired)
    );

    // Next-state, operand merge and issue-register load; CE low holds everything.
    always_comb begin
        // NOTE: every _d is given its hold value before any branch, so no path leaves a latch.
        state_d     = state_q;
        have_d      = have_q;
        opa_d       = opa_q;
        opb_d       = opb_q;
        cmd_d       = cmd_q;
        mode_d      = mode_q;
        cin_d       = cin_q;
        iss_opa_d   = iss_opa_q;
        iss_opb_d   = iss_opb_q;
        iss_cmd_d   = iss_cmd_q;
        iss_mode_d  = iss_mode_q;
        iss_cin_d   = iss_cin_q;
        inp_valid_d = inp_valid_q;
        timeout_d   = timeout_q;
        cmd_err_d   = cmd_err_q;
        need        = req_ops(mode_q, CMD_ARG_W'(cmd_q));

        if (CE) begin
            inp_valid_d = 2'b00;
            timeout_d   = 1'b0;
            cmd_err_d   = 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (accept && src.in_sel != 2'b00) begin
                        if (cmd_bad) begin
                            cmd_err_d = 1'b1;
                        end else begin
                            cmd_d  = src.in_cmd;
                            mode_d = src.in_mode;
                            cin_d  = src.in_cin;
                            have_d = src.in_sel;
                            if (src.in_sel[0]) opa_d = src.in_opa;
                            if (src.in_sel[1]) opb_d = src.in_opb;
                            need    = req_ops(src.in_mode, CMD_ARG_W'(src.in_cmd));
                            state_d = ((have_d & need) == need) ? ISSUE : WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (accept) begin
                        have_d = have_q | src.in_sel;
                        if (src.in_sel[0]) opa_d = src.in_opa;
                        if (src.in_sel[1]) opb_d = src.in_opb;
                    end
                    // A completing beat on the expiry cycle wins over the timeout.
                    if ((have_d & need) == need) begin
                        state_d = ISSUE;
                    end else if (expired) begin
                        state_d   = ISSUE;
                        timeout_d = 1'b1;
                    end
                end
                ISSUE:   state_d = IDLE;
                default: state_d = IDLE;
            endcase

            if (state_d == ISSUE && state_q != ISSUE) begin
                iss_opa_d   = opa_d;
                iss_opb_d   = opb_d;
                iss_cmd_d   = cmd_d;
                iss_mode_d  = mode_d;
                iss_cin_d   = cin_d;
                inp_valid_d = have_d;
            end
        end
    end

    // State, slot and output registers; reset drops any op in flight.
    always_ff @(posedge clk or negedge RST_N) begin
        if (!RST_N) begin
            state_q     <= IDLE;
            have_q      <= 2'b00;
            opa_q       <= '0;
            opb_q       <= '0;
            cmd_q       <= '0;
            mode_q      <= 1'b0;
            cin_q       <= 1'b0;
            iss_opa_q   <= '0;
            iss_opb_q   <= '0;
            iss_cmd_q   <= '0;
            iss_mode_q  <= 1'b0;
            iss_cin_q   <= 1'b0;
            inp_valid_q <= 2'b00;
            timeout_q   <= 1'b0;
            cmd_err_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking so every flop samples the pre-edge values of the others.
            state_q     <= state_d;
            have_q      <= have_d;
            opa_q       <= opa_d;
            opb_q       <= opb_d;
            cmd_q       <= cmd_d;
            mode_q      <= mode_d;
            cin_q       <= cin_d;
            iss_opa_q   <= iss_opa_d;
            iss_opb_q   <= iss_opb_d;
            iss_cmd_q   <= iss_cmd_d;
            iss_mode_q  <= iss_mode_d;
            iss_cin_q   <= iss_cin_d;
            inp_valid_q <= inp_valid_d;
            timeout_q   <= timeout_d;
            cmd_err_q   <= cmd_err_d;
        end
    end

    assign OPA       = iss_opa_q;
    assign OPB       = iss_opb_q;
    assign CMD       = iss_cmd_q;
    assign mode      = iss_mode_q;
    assign Cin       = iss_cin_q;
    assign inp_valid = inp_valid_q;
    assign timeout   = timeout_q;
    assign cmd_err   = cmd_err_q;
    assign busy      = (state_q != IDLE);
endmodule
